// File: rtl/fc_backward_mac.sv
// fc_backward_mac: sequential transposed matrix-vector product for the FC
// backward pass. grad_out[i] = (sum_j W[i][j] * delta[j]) >> BITWIDTH, using
// one signed multiplier and one accumulator over N*N cycles.
module fc_backward_mac #(
   parameter int BITWIDTH = 32,
   parameter int N        = 10
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                start_i,
   input  logic [N-1:0][BITWIDTH-1:0]          delta_in_i,
   input  logic [N-1:0][N-1:0][BITWIDTH-1:0]   connect_matrix_i,
   output logic                                busy_o,
   output logic                                done_o,
   output logic [N-1:0][BITWIDTH-1:0]          grad_out_o
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = 2 * BITWIDTH;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic {IDLE, MAC} state_e;

   state_e                       state_q, state_d;
   logic [N-1:0][BITWIDTH-1:0]   delta_q, delta_d;
   logic [N-1:0][BITWIDTH-1:0]   grad_q,  grad_d;
   logic [IW-1:0]                i_q, i_d, j_q, j_d;
   logic [AW-1:0]                acc_q, acc_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;

   logic [BITWIDTH-1:0]          w_sel, d_sel;
   logic [AW-1:0]                w_ext, d_ext, prod, sum;

   // Single MAC datapath: operands sign-extended to 2*BITWIDTH so the low
   // 2*BITWIDTH bits of the product equal the full signed product.
   always_comb begin
      w_sel = connect_matrix_i[i_q][j_q];
      d_sel = delta_q[j_q];
      w_ext = {{BITWIDTH{w_sel[BITWIDTH-1]}}, w_sel};
      d_ext = {{BITWIDTH{d_sel[BITWIDTH-1]}}, d_sel};
      prod  = w_ext * d_ext;
      sum   = acc_q + prod;
   end

   // Next-state logic: walk j across a row, write the row result on the last
   // column, then advance i; the final row raises done and returns to IDLE.
   always_comb begin
      state_d = state_q;
      delta_d = delta_q;
      grad_d  = grad_q;
      i_d     = i_q;
      j_d     = j_q;
      acc_d   = acc_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               delta_d = delta_in_i;
               i_d     = '0;
               j_d     = '0;
               acc_d   = '0;
               busy_d  = 1'b1;
               state_d = MAC;
            end
         end
         MAC: begin
            if (j_q != LAST) begin
               acc_d = sum;
               j_d   = j_q + IW'(1);
            end else begin
               // Upper half of the wrapped sum = floor(sum / 2^BITWIDTH).
               grad_d[i_q] = sum[AW-1:BITWIDTH];
               acc_d       = '0;
               j_d         = '0;
               if (i_q == LAST) begin
                  i_d     = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  i_d = i_q + IW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset; reset aborts any operation.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         delta_q <= '0;
         grad_q  <= '0;
         i_q     <= '0;
         j_q     <= '0;
         acc_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         delta_q <= delta_d;
         grad_q  <= grad_d;
         i_q     <= i_d;
         j_q     <= j_d;
         acc_q   <= acc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign grad_out_o = grad_q;

endmodule

// File: tb/tb_fc_backward_mac.sv
// Scoreboard bench for fc_backward_mac: each accepted start pushes the
// expected result vector and completion cycle; a monitor pops on done.
module tb_fc_backward_mac;
   localparam int BW = 32;
   localparam int N  = 10;

   typedef logic [N-1:0][BW-1:0]        vec_t;
   typedef logic [N-1:0][N-1:0][BW-1:0] mat_t;
   typedef struct { vec_t g; int cyc; } exp_t;

   logic clk = 1'b0;
   logic rst, start, busy, done;
   vec_t delta, grad;
   mat_t wm;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];

   fc_backward_mac #(.BITWIDTH(BW), .N(N)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .delta_in_i(delta), .connect_matrix_i(wm),
      .busy_o(busy), .done_o(done), .grad_out_o(grad)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain 64-bit signed dot products, result = upper half.
   function automatic vec_t model(input mat_t w, input vec_t d);
      vec_t r;
      longint s;
      int a, b;
      for (int i = 0; i < N; i++) begin
         s = 0;
         for (int j = 0; j < N; j++) begin
            a = w[i][j];
            b = d[j];
            s += longint'(a) * longint'(b);
         end
         r[i] = s[63:32];
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic chk_vec(input string nm, input vec_t act, input vec_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every done must match the oldest outstanding operation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected done=0 (cyc %0d)", cyc);
         end else begin
            e = sbq.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.cyc));
            chk_vec("grad_out", grad, e.g);
         end
      end
   end

   // Called right after a rising edge (+1); DUT assumed idle.
   task automatic do_start(input mat_t w, input vec_t d, output int e0);
      exp_t e;
      wm    = w;
      delta = d;
      start = 1'b1;
      e0    = cyc + 1;
      e.g   = model(w, d);
      e.cyc = e0 + N * N;
      sbq.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (sbq.size() != 0 && k < 300) begin @(posedge clk); #1; k++; end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected %0d pending", sbq.size());
         sbq.delete();
      end
   endtask

   task automatic rand_op(input int mode);
      mat_t w;
      vec_t d;
      int t, e0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            t = int'($urandom_range(0, 4000)) - 2000;
            w[i][j] = (mode == 0) ? $urandom : BW'(t <<< 12);
         end
         t = int'($urandom_range(0, 4000)) - 2000;
         d[i] = (mode == 0) ? $urandom : BW'(t <<< 14);
      end
      do_start(w, d, e0);
      wait_idle();
   endtask

   initial begin
      mat_t w;
      vec_t d;
      int e0, e1;

      rst = 1'b1; start = 1'b0; delta = '0; wm = '0;
      repeat (2) begin @(posedge clk); #1; end
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk_vec("rst_grad", grad, '0);
      rst = 1'b0;

      // Identity: grad[i] = i+1; row 0 lands after N edges, row 1 not yet.
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) w[i][j] = (i == j) ? 32'h0001_0000 : 32'h0;
         d[i] = BW'((i + 1) << 16);
      end
      do_start(w, d, e0);
      wait_cyc(e0 + N);
      chk("row0_ready", 64'(grad[0]), 64'(1));
      chk("row1_pending", 64'(grad[1]), 64'(0));
      chk("busy_mid", 64'(busy), 64'(1));
      wait_idle();
      chk("identity_g9", 64'(grad[9]), 64'(10));

      // Reset with nonzero outputs, start held high during reset.
      rst = 1'b1; start = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      chk("rst2_busy", 64'(busy), 64'(0));
      chk("rst2_done", 64'(done), 64'(0));
      chk_vec("rst2_grad", grad, '0);
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      chk("rst2_start_ignored", 64'(busy), 64'(0));

      // Transpose orientation: grad[i] = 10i+3.
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) w[i][j] = BW'((10 * i + j) << 16);
         d[i] = (i == 3) ? 32'h0001_0000 : 32'h0;
      end
      do_start(w, d, e0);
      wait_idle();
      chk("transpose_g7", 64'(grad[7]), 64'(73));

      // Signed / floor behaviour.
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) w[i][j] = 32'hFFFF_0000;
         d[i] = 32'h0001_0000;
      end
      do_start(w, d, e0);
      wait_idle();
      chk("neg10", 64'(grad[4]), 64'(32'hFFFF_FFF6));
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) w[i][j] = 32'hFFFF_FFFF;
         d[i] = 32'h1;
      end
      do_start(w, d, e0);
      wait_idle();
      chk("floor_neg1", 64'(grad[0]), 64'(32'hFFFF_FFFF));
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) w[i][j] = 32'h1;
         d[i] = 32'h1;
      end
      do_start(w, d, e0);
      wait_idle();
      chk("floor_zero", 64'(grad[0]), 64'(0));

      // Randomized operations.
      for (int r = 0; r < 6; r++) rand_op(r % 2);

      // Start while busy is ignored; delta changes after acceptance.
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) w[i][j] = $urandom;
         d[i] = $urandom;
      end
      do_start(w, d, e0);
      delta = ~d;
      wait_cyc(e0 + 40);
      start = 1'b1;
      delta = {N{32'h1234_5678}};
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_ignored_start", 64'(busy), 64'(1));
      // Start during the done cycle is accepted.
      wait_cyc(e0 + N * N);
      chk("done_pulse_seen", 64'(done), 64'(1));
      for (int i = 0; i < N; i++) d[i] = $urandom;
      do_start(w, d, e1);
      chk("b2b_busy", 64'(busy), 64'(1));
      wait_idle();

      // Mid-operation reset: no done afterwards.
      do_start(w, d, e0);
      wait_cyc(e0 + 50);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_done", 64'(done), 64'(0));
      chk_vec("abort_grad", grad, '0);
      sbq.delete();
      rst = 1'b0;
      repeat (120) begin @(posedge clk); #1; end
      chk("abort_idle", 64'(busy), 64'(0));

      // Fresh operation after abort.
      rand_op(0);
      rand_op(1);

      repeat (3) begin @(posedge clk); #1; end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
